// File: rtl/hilo_mult_div.sv
// Multi-cycle signed/unsigned multiply/divide with HI/LO result registers and MTHI/MTLO writes.
// Latency WIDTH+1 cycles start-to-done; start and MTHI/MTLO are ignored while busy.
module hilo_mult_div #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    state_t             state, state_nxt;
    logic               div_q;
    logic               sign_a, sign_b, b_zero;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   rem;

    logic               in_sa, in_sb;
    logic [WIDTH-1:0]   in_a_mag, in_b_mag;
    logic [WIDTH-1:0]   mul_add;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix, a_raw;
    logic [WIDTH-1:0]   res_hi, res_lo;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CALC;
            CALC:    if (cnt == LAST_ITER) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    // Signed ops (MULT, DIV) have op[0]=0; operands are reduced to magnitudes up front.
    always_comb begin
        in_sa    = ~op[0] & opa[WIDTH-1];
        in_sb    = ~op[0] & opb[WIDTH-1];
        in_a_mag = in_sa ? -opa : opa;
        in_b_mag = in_sb ? -opb : opb;
    end

    always_comb begin
        mul_add   = acc[0] ? a_mag : {WIDTH{1'b0}};
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mul_add};
        div_shift = {rem, acc[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, b_mag});
    end

    always_comb begin
        prod_fix = (sign_a ^ sign_b) ? -acc : acc;
        quot_fix = (sign_a ^ sign_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fix  = sign_a ? -rem : rem;
        a_raw    = sign_a ? -a_mag : a_mag;
        res_hi   = prod_fix[2*WIDTH-1:WIDTH];
        res_lo   = prod_fix[WIDTH-1:0];
        if (div_q) begin
            // Most-negative / -1 falls out naturally: magnitude quotient is the most-negative pattern.
            if (b_zero) begin
                res_hi = a_raw;
                res_lo = {WIDTH{1'b1}};
            end else begin
                res_hi = rem_fix;
                res_lo = quot_fix;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            div_q    <= 1'b0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            b_zero   <= 1'b0;
            a_mag    <= '0;
            b_mag    <= '0;
            cnt      <= '0;
            acc      <= '0;
            rem      <= '0;
            hi_out   <= '0;
            lo_out   <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (hi_we) hi_out <= wdata;
                    if (lo_we) lo_out <= wdata;
                    if (start) begin
                        div_q  <= op[1];
                        sign_a <= in_sa;
                        sign_b <= in_sb;
                        b_zero <= (opb == '0);
                        a_mag  <= in_a_mag;
                        b_mag  <= in_b_mag;
                        cnt    <= '0;
                        rem    <= '0;
                        acc    <= {{WIDTH{1'b0}}, op[1] ? in_a_mag : in_b_mag};
                    end
                end
                CALC: begin
                    cnt <= cnt + 1'b1;
                    if (!div_q) begin
                        acc <= {mul_sum, acc[WIDTH-1:1]};
                    end else begin
                        rem              <= div_ge ? (div_shift[WIDTH-1:0] - b_mag) : div_shift[WIDTH-1:0];
                        acc[WIDTH-1:0]   <= {acc[WIDTH-2:0], div_ge};
                    end
                end
                FIX: begin
                    hi_out   <= res_hi;
                    lo_out   <= res_lo;
                    done     <= 1'b1;
                    div_zero <= div_q & b_zero;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_mult_div.sv
// Drives a 32-bit and an 8-bit instance in lockstep; a negedge monitor scores each done against a reference model.
module tb_hilo_mult_div;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          t;
    } exp_t;

    logic        CLK, RST, start, hi_we, lo_we;
    logic [1:0]  op;
    logic [31:0] opa, opb, wdata;
    logic [31:0] hi32, lo32;
    logic [7:0]  hi8, lo8;
    logic        busy32, done32, dz32, busy8, done8, dz8;

    logic [31:0] hi_a[2], lo_a[2];
    logic        busy_a[2], done_a[2], dz_a[2];
    int          W[2] = '{32, 8};

    exp_t        scb[2][$];
    logic [31:0] exp_hi[2], exp_lo[2];
    int          bc[2];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    hilo_mult_div #(.WIDTH(32)) u_dut32 (
        .CLK(CLK), .RST(RST), .start(start), .op(op), .opa(opa), .opb(opb),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .hi_out(hi32), .lo_out(lo32), .busy(busy32), .done(done32), .div_zero(dz32)
    );

    hilo_mult_div #(.WIDTH(8)) u_dut8 (
        .CLK(CLK), .RST(RST), .start(start), .op(op), .opa(opa[7:0]), .opb(opb[7:0]),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata[7:0]),
        .hi_out(hi8), .lo_out(lo8), .busy(busy8), .done(done8), .div_zero(dz8)
    );

    assign hi_a[0] = hi32;            assign hi_a[1] = {24'd0, hi8};
    assign lo_a[0] = lo32;            assign lo_a[1] = {24'd0, lo8};
    assign busy_a[0] = busy32;        assign busy_a[1] = busy8;
    assign done_a[0] = done32;        assign done_a[1] = done8;
    assign dz_a[0] = dz32;            assign dz_a[1] = dz8;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Reference: plain integer arithmetic on the operands' signed/unsigned values.
    function automatic exp_t model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input int w);
        exp_t        e;
        logic [63:0] mask, ua, ub, bits;
        longint      sa, sbv, q, r;
        mask = (64'd1 << w) - 64'd1;
        ua   = {32'd0, a} & mask;
        ub   = {32'd0, b} & mask;
        sa   = ua[w-1] ? longint'(ua) - (longint'(1) << w) : longint'(ua);
        sbv  = ub[w-1] ? longint'(ub) - (longint'(1) << w) : longint'(ub);
        e.dz = 1'b0;
        e.t  = 0;
        e.hi = '0;
        e.lo = '0;
        case (o)
            2'd0, 2'd1: begin
                if (o == 2'd0) bits = sa * sbv;
                else           bits = ua * ub;
                e.hi = 32'((bits >> w) & mask);
                e.lo = 32'(bits & mask);
            end
            default: begin
                if (ub == 0) begin
                    e.hi = 32'(ua);
                    e.lo = 32'(mask);
                    e.dz = 1'b1;
                end else if (o == 2'd2 && sa == -(longint'(1) << (w - 1)) && sbv == -1) begin
                    e.lo = 32'(64'd1 << (w - 1));
                    e.hi = '0;
                end else if (o == 2'd2) begin
                    q = sa / sbv;
                    r = sa % sbv;
                    bits = q;
                    e.lo = 32'(bits & mask);
                    bits = r;
                    e.hi = 32'(bits & mask);
                end else begin
                    e.lo = 32'(ua / ub);
                    e.hi = 32'(ua % ub);
                end
            end
        endcase
        return e;
    endfunction

    always @(negedge CLK) begin
        if (!RST) begin
            for (int i = 0; i < 2; i++) begin
                if (busy_a[i]) bc[i]++;
                if (done_a[i]) begin
                    if (scb[i].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL spurious_done w%0d: got done=1, required no done", W[i]);
                    end else begin
                        exp_t e;
                        e = scb[i].pop_front();
                        chk($sformatf("hi w%0d", W[i]), 64'(hi_a[i]), 64'(e.hi));
                        chk($sformatf("lo w%0d", W[i]), 64'(lo_a[i]), 64'(e.lo));
                        chk($sformatf("div_zero w%0d", W[i]), 64'(dz_a[i]), 64'(e.dz));
                        chk($sformatf("latency w%0d", W[i]), 64'(cyc - e.t - 1), 64'(W[i] + 1));
                        chk($sformatf("busy_len w%0d", W[i]), 64'(bc[i]), 64'(W[i] + 1));
                        chk($sformatf("busy_at_done w%0d", W[i]), 64'(busy_a[i]), 64'd0);
                        exp_hi[i] = e.hi;
                        exp_lo[i] = e.lo;
                    end
                    bc[i] = 0;
                end else if (dz_a[i]) begin
                    checks++;
                    errors++;
                    $display("FAIL stray_div_zero w%0d: got 1 without done, required 0", W[i]);
                end
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (busy_a[0] || busy_a[1] || scb[0].size() != 0 || scb[1].size() != 0) begin
            if (n == 300) begin
                checks++;
                errors++;
                $display("FAIL wait_idle: got still busy after %0d cycles, required idle", n);
                scb[0].delete();
                scb[1].delete();
                return;
            end
            n++;
            @(posedge CLK);
            #2;
        end
    endtask

    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        wait_idle();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("hold_hi w%0d", W[i]), 64'(hi_a[i]), 64'(exp_hi[i]));
            chk($sformatf("hold_lo w%0d", W[i]), 64'(lo_a[i]), 64'(exp_lo[i]));
        end
        op = o; opa = a; opb = b; start = 1'b1;
        for (int i = 0; i < 2; i++) begin
            e   = model(o, a, b, W[i]);
            e.t = cyc;
            scb[i].push_back(e);
        end
        @(posedge CLK);
        #2;
        start = 1'b0;
        op    = 2'($urandom_range(0, 3));
        opa   = $urandom;
        opb   = $urandom;
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%s hi w%0d", tag, W[i]), 64'(hi_a[i]), 64'd0);
            chk($sformatf("%s lo w%0d", tag, W[i]), 64'(lo_a[i]), 64'd0);
            chk($sformatf("%s busy w%0d", tag, W[i]), 64'(busy_a[i]), 64'd0);
            chk($sformatf("%s done w%0d", tag, W[i]), 64'(done_a[i]), 64'd0);
            chk($sformatf("%s div_zero w%0d", tag, W[i]), 64'(dz_a[i]), 64'd0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no end of test, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a, b;
        RST = 1'b1; start = 1'b0; op = 2'd0; opa = '0; opb = '0;
        hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
        for (int i = 0; i < 2; i++) begin exp_hi[i] = '0; exp_lo[i] = '0; bc[i] = 0; end
        #1;
        check_reset_outputs("reset");
        repeat (2) @(posedge CLK);
        #2 RST = 1'b0;

        issue(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
        issue(2'd0, 32'hFFFFFFFD, 32'd5);
        issue(2'd0, 32'h80000000, 32'h80000000);
        issue(2'd2, 32'hFFFFFFF9, 32'd2);
        issue(2'd3, 32'd7, 32'd2);
        issue(2'd2, 32'h80000000, 32'hFFFFFFFF);
        issue(2'd2, 32'h00000080, 32'hFFFFFFFF);
        issue(2'd3, 32'd100, 32'd0);
        issue(2'd2, 32'hFFFFFFFB, 32'd0);

        // Mid-operation start and MTHI must both be dropped.
        issue(2'd1, 32'h12345678, 32'h9ABCDEF1);
        repeat (2) @(posedge CLK);
        #2;
        start = 1'b1; op = 2'd0; opa = 32'h11111111; opb = 32'h22222222;
        hi_we = 1'b1; wdata = 32'h0000DEAD;
        @(posedge CLK);
        #2;
        start = 1'b0; hi_we = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("busy_hi_we w%0d", W[i]), 64'(hi_a[i]), 64'(exp_hi[i]));
            chk($sformatf("busy_still w%0d", W[i]), 64'(busy_a[i]), 64'd1);
        end

        wait_idle();
        lo_we = 1'b1; wdata = 32'h00001234;
        @(posedge CLK);
        #2;
        lo_we = 1'b0;
        exp_lo[0] = 32'h00001234;
        exp_lo[1] = 32'h00000034;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("mtlo lo w%0d", W[i]), 64'(lo_a[i]), 64'(exp_lo[i]));
            chk($sformatf("mtlo hi w%0d", W[i]), 64'(hi_a[i]), 64'(exp_hi[i]));
        end

        // MTHI coinciding with start lands first; the result overwrites it later.
        wait_idle();
        hi_we = 1'b1; wdata = 32'hCAFE0042;
        issue(2'd3, 32'd1000, 32'd7);
        hi_we = 1'b0;
        chk("mthi_with_start w32", 64'(hi32), 64'h00000000CAFE0042);
        chk("mthi_with_start w8", 64'(hi8), 64'h42);

        for (int n = 0; n < 60; n++) begin
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 9))
                0: b = '0;
                1: b = '1;
                2: begin a = 32'h80000000; b = '1; end
                3: begin a = 32'h00000080; b = 32'h000000FF; end
                4: b = $urandom_range(1, 15);
                default: ;
            endcase
            issue(2'($urandom_range(0, 3)), a, b);
        end

        // Reset in the middle of a divide aborts both instances with no done.
        issue(2'd2, 32'hFFFFFC18, 32'd7);
        repeat (6) @(posedge CLK);
        #3 RST = 1'b1;
        #1;
        check_reset_outputs("abort");
        for (int i = 0; i < 2; i++) begin
            scb[i].delete();
            bc[i] = 0;
            exp_hi[i] = '0;
            exp_lo[i] = '0;
        end
        @(posedge CLK);
        #2 RST = 1'b0;
        repeat (45) @(posedge CLK);
        #2;
        check_reset_outputs("post_abort");

        issue(2'd1, 32'h0000FFFF, 32'h00010001);
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/hilo_mult_div.md
# hilo_mult_div

Parametrised multi-cycle multiply/divide unit with integrated HI/LO result registers, the successor to the ALU-embedded mult/div path and the separate hi/lo registers in the multi-cycle datapath. It performs signed and unsigned multiply and divide with a start/done handshake and a constant, known latency. It also services MTHI/MTLO writes and feeds MFHI/MFLO through the register-write mux. It sits beside the ALU; the control unit stalls on `busy` or waits for `done`.

## Interface
Parameters:
- `WIDTH`, 32: operand, HI and LO width; must be at least 4.
- `CNT_W`, $clog2(WIDTH)+1: iteration counter width.

Ports:
- `CLK`, in, 1: sole clock, rising edge.
- `RST`, in, 1: reset, asynchronous, active-high.
- `start`, in, 1: launch an operation; sampled only in IDLE.
- `op`, in, 2: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with `start`.
- `opa`, in, WIDTH: rs operand (multiplicand or dividend); sampled with `start`.
- `opb`, in, WIDTH: rt operand (multiplier or divisor); sampled with `start`.
- `hi_we`, in, 1: MTHI strobe.
- `lo_we`, in, 1: MTLO strobe.
- `wdata`, in, WIDTH: MTHI/MTLO data.
- `hi_out`, out, WIDTH: HI register.
- `lo_out`, out, WIDTH: LO register.
- `busy`, out, 1: operation in progress.
- `done`, out, 1: one-cycle pulse; HI/LO hold the new result in this cycle.
- `div_zero`, out, 1: pulses with `done` for DIV/DIVU when the divisor is 0.

## Operation
State machine: IDLE, CALC, FIX.

IDLE:
- `start`=1 captures `op`.
- Captures |opa| and |opb| for signed ops, raw values for unsigned ops.
- Records the operand signs and the divisor-zero condition.
- Clears the counter and moves to CALC.
- `start` is ignored outside IDLE.

CALC:
- Multiply: shift-add, one multiplier bit per cycle, into a 2*WIDTH accumulator.
- Divide: restoring division, one quotient bit per cycle, with a WIDTH+1 partial remainder.
- The counter increments each cycle. After WIDTH iterations, move to FIX.

FIX (one cycle), writing HI/LO and asserting `done`, then returning to IDLE:
- MULT: product negated as a 2*WIDTH value when sign(opa)^sign(opb); HI = upper half, LO = lower half.
- MULTU: HI = upper half, LO = lower half, no fixup.
- DIV: quotient negated when the signs differ; remainder takes the sign of the dividend. LO = quotient, HI = remainder.
- Signed overflow (most-negative / -1): LO = most-negative, HI = 0. No flag.
- Divisor 0 (DIV or DIVU): HI = opa as captured (unsigned raw value), LO = all ones, `div_zero`=1. Latency is unchanged.

MTHI/MTLO:
- `hi_we`/`lo_we` in IDLE write `wdata` at the edge.
- They are ignored while `busy`=1.
- If a write and `start` coincide in IDLE, the write takes effect, and the result later overwrites it.

Other rules:
- The captured operands are isolated from later changes on `opa`/`opb`.
- All arithmetic is modulo 2^WIDTH per half.

## Timing
- Reset values: `hi_out`=0, `lo_out`=0, `busy`=0, `done`=0, `div_zero`=0, state IDLE, counter 0.
- Reset asserted mid-operation aborts immediately to the reset values; no `done` is issued.
- `start` is sampled at edge k. `busy`=1 from edge k until edge k+WIDTH+1.
- At edge k+WIDTH+1: HI/LO update, `done`=1 and `busy`=0. Latency is WIDTH+1 cycles (33 for WIDTH=32).
- `done` and `div_zero` are registered and high for exactly one cycle.
- `start` held high in the `done` cycle launches the next operation at that edge, giving back-to-back issue every WIDTH+2 cycles.
- `hi_out`/`lo_out` are registered and stable except at a FIX edge or an idle MTHI/MTLO edge.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → `done` 33 cycles after start, HI=0xFFFFFFFE, LO=0x00000001, `busy` high for exactly 33 cycles.
- MULT -3 × 5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1. Then MULT 0x80000000 × 0x80000000 → HI=0x40000000, LO=0.
- DIV -7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7 / 2 → LO=3, HI=1. DIV 0x80000000 / -1 → LO=0x80000000, HI=0.
- DIVU 100 / 0 → HI=0x00000064, LO=0xFFFFFFFF, `div_zero`=1 for one cycle.
- Start a MULTU; mid-operation pulse `start` with new operands and `hi_we` with 0xDEAD → both ignored, result matches the first operation. In IDLE, `lo_we` 0x1234 → `lo_out`=0x1234 next cycle.
- Assert `RST` 10 cycles into a DIV → all outputs 0 at once, no `done`. Repeat the full suite with WIDTH=8: MULTU 0xFF × 0xFF → HI=0xFE, LO=0x01 after 9 cycles.
